// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerometer BCD converter.
// Provides the FSM state enum, widths and a power-of-ten helper.
package accel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } conv_state_t;

  localparam int SAMPLE_W = 16;
  localparam int DIGIT_W  = 4;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/accel_bcd_converter_dabble.sv
// One double-dabble step: add-3 correction on every BCD digit >= 5,
// then shift {bcd, sh} left by one. Ports: bcd/sh in, bcd_nxt/sh_nxt out.
module bcd_dabble_step
  import accel_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SH_W       = 13
) (
  input  logic [NUM_DIGITS*DIGIT_W-1:0] bcd,
  input  logic [SH_W-1:0]               sh,
  output logic [NUM_DIGITS*DIGIT_W-1:0] bcd_nxt,
  output logic [SH_W-1:0]               sh_nxt
);

  localparam int BCD_W = NUM_DIGITS * DIGIT_W;

  logic [BCD_W-1:0] bcd_c;

  always_comb begin
    bcd_c = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[i*DIGIT_W +: DIGIT_W] >= 4'd5) begin
        bcd_c[i*DIGIT_W +: DIGIT_W] =
          bcd[i*DIGIT_W +: DIGIT_W] + 4'd3;
      end
    end
    {bcd_nxt, sh_nxt} = {bcd_c[BCD_W-2:0], sh, 1'b0};
  end

endmodule

// File: rtl/accel_bcd_converter.sv
// Signed left-justified accel sample -> sign + mg magnitude in packed BCD.
// Ports: in_valid/in_ready/in_data, out_valid/out_ready/out_sign/out_digits/out_ovf.
module accel_bcd_converter
  import accel_pkg::*;
#(
  parameter int DATA_BITS  = 10,
  parameter int SCALE_MG   = 4,
  parameter int NUM_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SAMPLE_W-1:0]           in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sign,
  output logic [NUM_DIGITS*DIGIT_W-1:0] out_digits,
  output logic                          out_ovf
);

  localparam int PROD_W = DATA_BITS + $clog2(SCALE_MG) + 1;
  localparam int BCD_W  = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(PROD_W + 1);
  localparam int MAXV   = pow10(NUM_DIGITS) - 1;
  localparam logic [31:0] MAXV_U = 32'(MAXV);

  conv_state_t state, state_n;

  logic [DATA_BITS-1:0] samp;
  logic [PROD_W-1:0]    shreg;
  logic [BCD_W-1:0]     bcd;
  logic [CNT_W-1:0]     cnt;
  logic                 neg_r;
  logic                 nz_r;
  logic                 ovf_r;

  logic [DATA_BITS:0]   sx;
  logic [DATA_BITS:0]   mag;
  logic [PROD_W-1:0]    prod_raw;
  logic [PROD_W-1:0]    prod_sat;
  logic                 too_big;
  logic                 last;
  logic [BCD_W-1:0]     bcd_nxt;
  logic [PROD_W-1:0]    sh_nxt;

  assign in_ready = (state == IDLE);

  bcd_dabble_step #(
    .NUM_DIGITS (NUM_DIGITS),
    .SH_W       (PROD_W)
  ) u_step (
    .bcd     (bcd),
    .sh      (shreg),
    .bcd_nxt (bcd_nxt),
    .sh_nxt  (sh_nxt)
  );

  // One extra bit so the most negative code negates to a positive value.
  always_comb begin
    sx       = {samp[DATA_BITS-1], samp};
    mag      = samp[DATA_BITS-1] ? (~sx + (DATA_BITS+1)'(1)) : sx;
    prod_raw = PROD_W'(mag) * PROD_W'(SCALE_MG);
    too_big  = 32'(prod_raw) > MAXV_U;
    prod_sat = too_big ? PROD_W'(MAXV) : prod_raw;
    last     = (cnt == CNT_W'(PROD_W - 1));
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (in_valid) state_n = LOAD;
      LOAD:  state_n = SHIFT;
      SHIFT: if (last) state_n = DONE;
      DONE:  if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      samp       <= '0;
      shreg      <= '0;
      bcd        <= '0;
      cnt        <= '0;
      neg_r      <= 1'b0;
      nz_r       <= 1'b0;
      ovf_r      <= 1'b0;
      out_valid  <= 1'b0;
      out_sign   <= 1'b0;
      out_digits <= '0;
      out_ovf    <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            samp <= in_data[SAMPLE_W-1 -: DATA_BITS];
          end
        end
        LOAD: begin
          neg_r <= samp[DATA_BITS-1];
          nz_r  <= (prod_sat != '0);
          ovf_r <= too_big;
          shreg <= prod_sat;
          bcd   <= '0;
          cnt   <= '0;
        end
        SHIFT: begin
          bcd   <= bcd_nxt;
          shreg <= sh_nxt;
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            out_digits <= bcd_nxt;
            out_sign   <= neg_r && nz_r;
            out_ovf    <= ovf_r;
            out_valid  <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_bcd_converter.sv
// Directed bench for accel_bcd_converter (default and 3-digit variants).
// Hand-computed BCD results, latency, stall, and reset checks.
module tb_accel_bcd_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign;
  logic [15:0] out_digits;
  logic        out_ovf;

  logic        in_valid3 = 1'b0;
  logic        in_ready3;
  logic [15:0] in_data3 = '0;
  logic        out_valid3;
  logic        out_ready3 = 1'b0;
  logic        out_sign3;
  logic [11:0] out_digits3;
  logic        out_ovf3;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  accel_bcd_converter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_digits (out_digits),
    .out_ovf    (out_ovf)
  );

  accel_bcd_converter #(.NUM_DIGITS(3)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid3),
    .in_ready   (in_ready3),
    .in_data    (in_data3),
    .out_valid  (out_valid3),
    .out_ready  (out_ready3),
    .out_sign   (out_sign3),
    .out_digits (out_digits3),
    .out_ovf    (out_ovf3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic conv(input string tag,
                      input logic [15:0] d,
                      input logic s,
                      input logic [15:0] dig,
                      input logic ovf);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 40);
    chk({tag, "_lat"}, 32'(n), 32'd14);
    chk({tag, "_sign"}, 32'(out_sign), 32'(s));
    chk({tag, "_dig"}, 32'(out_digits), 32'(dig));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(ovf));
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("take_valid", 32'(out_valid), 32'd0);
    chk("take_idle", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_dig", 32'(out_digits), 32'd0);
    chk("rst_sign", 32'(out_sign), 32'd0);
    #20 rst_n = 1'b1;
    tick();

    conv("m1", 16'hFFFF, 1'b1, 16'h0004, 1'b0);
    take();
    conv("neg_max", 16'h8000, 1'b1, 16'h2048, 1'b0);
    take();
    conv("pos_max", 16'h7FC0, 1'b0, 16'h2044, 1'b0);
    take();
    conv("zero", 16'h003F, 1'b0, 16'h0000, 1'b0);
    take();

    // Stall: result held, in_ready low, stray in_valid ignored.
    conv("pre", 16'h7FC0, 1'b0, 16'h2044, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h8000;
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_dig", 32'(out_digits), 32'h2044);
      chk("stall_rdy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    take();
    chk("hold_dig", 32'(out_digits), 32'h2044);
    conv("one", 16'h0040, 1'b0, 16'h0004, 1'b0);
    take();

    // Reset mid-shift.
    in_valid = 1'b1;
    in_data  = 16'h8000;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_dig", 32'(out_digits), 32'd0);
    chk("mrst_rdy", 32'(in_ready), 32'd1);
    #10 rst_n = 1'b1;
    tick();
    n = 0;
    while (n < 20 && !out_valid) begin
      tick();
      n++;
    end
    chk("mrst_nopartial", 32'(out_valid), 32'd0);
    conv("after_rst", 16'hFFC0, 1'b1, 16'h0004, 1'b0);
    take();

    // Three-digit variant saturates.
    in_valid3 = 1'b1;
    in_data3  = 16'h8000;
    tick();
    in_valid3 = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid3 && n < 40);
    chk("d3_lat", 32'(n), 32'd14);
    chk("d3_dig", 32'(out_digits3), 32'h999);
    chk("d3_ovf", 32'(out_ovf3), 32'd1);
    chk("d3_sign", 32'(out_sign3), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
